cp0_unit: RTL



---
 rtl/cp0_unit_if.sv | 37 +++
 rtl/cp0_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: connection between the pipeline's exception/writeback stage
// and the CP0 register unit.
//   master modport : pipeline side (drives MTC0/MFC0, exception, ERET, hw_int)
//   slave modport  : cp0_unit side (returns read data, EPC/Status/Cause, intr_req)
interface cp0_unit_if #(
    parameter int N_HWINT = 6
);
    logic [N_HWINT-1:0] hw_int;
    logic               mtc0_en;
    logic [4:0]         mtc0_addr;
    logic [31:0]        mtc0_data;
    logic [4:0]         mfc0_addr;
    logic [31:0]        mfc0_data;
    logic               exc_valid;
    logic [4:0]         exc_code;
    logic               exc_bd;
    logic [31:0]        exc_epc;
    logic               exc_bva_valid;
    logic [31:0]        exc_bva;
    logic               eret;
    logic [31:0]        epc_out;
    logic [31:0]        status_out;
    logic [31:0]        cause_out;
    logic               intr_req;

    modport master (
        output hw_int, mtc0_en, mtc0_addr, mtc0_data, mfc0_addr,
               exc_valid, exc_code, exc_bd, exc_epc, exc_bva_valid, exc_bva, eret,
        input  mfc0_data, epc_out, status_out, cause_out, intr_req
    );

    modport slave (
        input  hw_int, mtc0_en, mtc0_addr, mtc0_data, mfc0_addr,
               exc_valid, exc_code, exc_bd, exc_epc, exc_bva_valid, exc_bva, eret,
        output mfc0_data, epc_out, status_out, cause_out, intr_req
    );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS32 coprocessor-0 register unit (BadVAddr, Count, Compare,
// Status, Cause, EPC) with exception entry, ERET and interrupt request.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - cp0_unit_if.slave (MTC0/MFC0 access, exception commit, ERET,
//          hw_int lines, EPC/Status/Cause outputs, intr_req)
// Parameters: N_HWINT (1..6 hardware interrupt lines), TIMER_LINE (< 6).
// Build option: define CP0_TIMER_EN to include the Count/Compare timer.
module cp0_unit #(
    parameter int N_HWINT    = 6,
    parameter int TIMER_LINE = 5
) (
    input  logic        clk,
    input  logic        rst,
    cp0_unit_if.slave   bus
);
    localparam int TI_BIT = 2 + TIMER_LINE;

    logic [31:0] badvaddr;
    logic [31:0] epc;
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;
    logic [4:0]  exc_code_q;
    logic        ti;
    logic [5:0]  hw_sample;
    logic [7:0]  ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        wr;

    // An exception squashes the MTC0/ERET in flight; ERET outranks MTC0.
    assign wr = bus.mtc0_en & ~bus.exc_valid & ~bus.eret;

    always_comb begin
        hw_sample = '0;
        for (int k = 0; k < N_HWINT; k++) hw_sample[k] = bus.hw_int[k];
    end

    always_comb begin
        ip         = {ip_hw, ip_sw};
        ip[TI_BIT] = ip_hw[TIMER_LINE] | ti;
    end

    assign status_val = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause_val  = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr   <= '0;
            epc        <= '0;
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ip_sw      <= '0;
            ip_hw      <= '0;
            exc_code_q <= '0;
        end else begin
            ip_hw <= hw_sample;
            if (bus.exc_valid) begin
                exc_code_q <= bus.exc_code;
                exl        <= 1'b1;
                // Nested exceptions keep the original restart point.
                if (!exl) begin
                    epc <= bus.exc_epc;
                    bd  <= bus.exc_bd;
                end
                if (bus.exc_bva_valid) badvaddr <= bus.exc_bva;
            end else if (bus.eret) begin
                exl <= 1'b0;
            end else if (bus.mtc0_en) begin
                case (bus.mtc0_addr)
                    5'd12: begin
                        im  <= bus.mtc0_data[15:8];
                        exl <= bus.mtc0_data[1];
                        ie  <= bus.mtc0_data[0];
                    end
                    5'd13:   ip_sw <= bus.mtc0_data[9:8];
                    5'd14:   epc   <= bus.mtc0_data;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        toggle;
    logic        inc_q;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = wr && (bus.mtc0_addr == 5'd9);
    assign wr_compare = wr && (bus.mtc0_addr == 5'd11);

    // inc_q marks the cycle right after an increment, so the equality check
    // only fires on a counted match (a direct Count write never sets TI).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            toggle  <= 1'b0;
            inc_q   <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (wr_count) begin
                count  <= bus.mtc0_data;
                toggle <= 1'b0;
                inc_q  <= 1'b0;
            end else begin
                toggle <= ~toggle;
                inc_q  <= toggle;
                if (toggle) count <= count + 32'd1;
            end
            if (wr_compare) begin
                compare <= bus.mtc0_data;
                ti      <= 1'b0;
            end else if (inc_q && (count == compare)) begin
                ti <= 1'b1;
            end
        end
    end

    assign count_val   = count;
    assign compare_val = compare;
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign ti          = 1'b0;
`endif

    always_comb begin
        case (bus.mfc0_addr)
            5'd8:    bus.mfc0_data = badvaddr;
            5'd9:    bus.mfc0_data = count_val;
            5'd11:   bus.mfc0_data = compare_val;
            5'd12:   bus.mfc0_data = status_val;
            5'd13:   bus.mfc0_data = cause_val;
            5'd14:   bus.mfc0_data = epc;
            default: bus.mfc0_data = '0;
        endcase
    end

    assign bus.epc_out    = epc;
    assign bus.status_out = status_val;
    assign bus.cause_out  = cause_val;
    assign bus.intr_req   = ie & ~exl & (|(ip & im));
endmodule
